// File: rtl/prm_edge_mask_accum.sv
// prm_edge_mask_accum: ORs the checker-bank edge masks over one frame, then drains the bitmap as OUT_W-bit words.
// Build option PRM_EDGE_BLKCNT_EN adds blocked_count, the popcount of all drained words.
module prm_edge_mask_accum #(
    parameter int NUM_EDGES = 512,
    parameter int OUT_W     = 32,
    parameter int OBS_CNT_W = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   frame_start,
    input  logic                                   mask_valid,
    output logic                                   mask_ready,
    input  logic [NUM_EDGES-1:0]                   mask_vec,
    input  logic                                   mask_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUT_W-1:0]                       out_data,
    output logic [((NUM_EDGES/OUT_W > 1) ? $clog2(NUM_EDGES/OUT_W) : 1)-1:0] out_idx,
    output logic                                   out_last,
    output logic                                   frame_done,
    output logic                                   busy,
    output logic [OBS_CNT_W-1:0]                   obs_count
`ifdef PRM_EDGE_BLKCNT_EN
    ,
    output logic [$clog2(NUM_EDGES+1)-1:0]         blocked_count
`endif
);

    // state | meaning
    // IDLE  | waiting for frame_start; bitmap and obs_count hold the last frame
    // ACCUM | accepting mask vectors, ORing them into the bitmap
    // DRAIN | presenting bitmap words to the pruning stage
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int NUM_WORDS = NUM_EDGES / OUT_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [1:0]           state;
    logic [NUM_EDGES-1:0] bitmap;
    logic [OUT_W-1:0]     word_sel;
    logic                 beat_acc;
    logic                 out_hs;
    logic                 is_last_word;

    always_comb begin
        word_sel = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (out_idx == IDX_W'(w)) begin
                word_sel = bitmap[w*OUT_W +: OUT_W];
            end
        end
    end

    assign is_last_word = (out_idx == LAST_IDX);
    assign mask_ready   = (state == ACCUM);
    assign out_valid    = (state == DRAIN);
    assign busy         = (state != IDLE);
    assign beat_acc     = mask_valid & mask_ready;
    assign out_hs       = out_valid & out_ready;

    // Gated by DRAIN so the idle bus stays quiet even though the bitmap is retained.
    assign out_data = (state == DRAIN) ? word_sel : '0;
    assign out_last = (state == DRAIN) & is_last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bitmap     <= '0;
            obs_count  <= '0;
            out_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state     <= ACCUM;
                        bitmap    <= '0;
                        obs_count <= '0;
                    end
                end
                ACCUM: begin
                    if (beat_acc) begin
                        bitmap <= bitmap | mask_vec;
                        if (obs_count != '1) begin
                            obs_count <= obs_count + OBS_CNT_W'(1);
                        end
                        if (mask_last) begin
                            state   <= DRAIN;
                            out_idx <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (is_last_word) begin
                            out_idx    <= '0;
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            out_idx <= out_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRM_EDGE_BLKCNT_EN
    localparam int CNT_W = $clog2(NUM_EDGES + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [OUT_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int b = 0; b < OUT_W; b++) begin
            c = c + CNT_W'(v[b]);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocked_count <= '0;
        end else if (state == IDLE && frame_start) begin
            blocked_count <= '0;
        end else if (out_hs) begin
            blocked_count <= blocked_count + popcount(word_sel);
        end
    end
`endif

endmodule
